// File: rtl/ar_rr_arbiter_if.sv
// rtl/ar_rr_arbiter_if.sv - AR request, read-completion and FIFO-side signals of one crossbar slave port
interface ar_rr_arbiter_if #(
    parameter int NUM_M      = 4,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int SIZE_WIDTH = 3
);
    localparam int MIDX_W = $clog2(NUM_M);

    logic [NUM_M-1:0]            m_ARVALID;
    logic [NUM_M-1:0]            m_ARREADY;
    logic [NUM_M*ID_WIDTH-1:0]   m_ARID;
    logic [NUM_M*ADDR_WIDTH-1:0] m_ARADDR;
    logic [NUM_M*LEN_WIDTH-1:0]  m_ARLEN;
    logic [NUM_M*SIZE_WIDTH-1:0] m_ARSIZE;
    logic [NUM_M*2-1:0]          m_ARBURST;
    logic [NUM_M-1:0]            r_done;
    logic                        fifo_full;
    logic                        push;
    logic [MIDX_W+ID_WIDTH-1:0]  out_ARID;
    logic [ADDR_WIDTH-1:0]       out_ARADDR;
    logic [LEN_WIDTH-1:0]        out_ARLEN;
    logic [SIZE_WIDTH-1:0]       out_ARSIZE;
    logic [1:0]                  out_ARBURST;

    modport master (
        output m_ARVALID, m_ARID, m_ARADDR, m_ARLEN, m_ARSIZE, m_ARBURST, r_done, fifo_full,
        input  m_ARREADY, push, out_ARID, out_ARADDR, out_ARLEN, out_ARSIZE, out_ARBURST
    );

    modport slave (
        input  m_ARVALID, m_ARID, m_ARADDR, m_ARLEN, m_ARSIZE, m_ARBURST, r_done, fifo_full,
        output m_ARREADY, push, out_ARID, out_ARADDR, out_ARLEN, out_ARSIZE, out_ARBURST
    );
endinterface

// File: rtl/ar_rr_arbiter.sv
// rtl/ar_rr_arbiter.sv - Round-robin AR arbiter with per-master outstanding-read limit and one-entry output stage
module ar_rr_arbiter #(
    parameter int NUM_M      = 4,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int SIZE_WIDTH = 3,
    parameter int MAX_OUT    = 4
) (
    input  logic           clk,
    input  logic           nrst,
    ar_rr_arbiter_if.slave bus
);
    localparam int MIDX_W = $clog2(NUM_M);
    localparam int CNT_W  = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_OUT);
    localparam logic [MIDX_W-1:0] LAST_IDX = MIDX_W'(NUM_M - 1);

    logic [MIDX_W-1:0]          rr_ptr;
    logic [CNT_W-1:0]           cnt [NUM_M];
    logic                       out_valid;
    logic [MIDX_W+ID_WIDTH-1:0] out_id;
    logic [ADDR_WIDTH-1:0]      out_addr;
    logic [LEN_WIDTH-1:0]       out_len;
    logic [SIZE_WIDTH-1:0]      out_size;
    logic [1:0]                 out_burst;

    logic [NUM_M-1:0]      eligible;
    logic [NUM_M-1:0]      ready;
    logic                  any_elig;
    logic                  push;
    logic                  can_load;
    logic                  accept;
    logic [MIDX_W-1:0]     g;
    logic [ID_WIDTH-1:0]   sel_id;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic [SIZE_WIDTH-1:0] sel_size;
    logic [1:0]            sel_burst;

    function automatic logic [MIDX_W-1:0] wrap_add(input logic [MIDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_M) s = s - NUM_M;
        return MIDX_W'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_M; i++) begin
            eligible[i] = bus.m_ARVALID[i] && (cnt[i] < CNT_MAX);
        end
    end

    // First eligible master at or above rr_ptr, wrapping to 0.
    always_comb begin
        any_elig = 1'b0;
        g        = rr_ptr;
        for (int k = 0; k < NUM_M; k++) begin
            if (!any_elig && eligible[wrap_add(rr_ptr, k)]) begin
                any_elig = 1'b1;
                g        = wrap_add(rr_ptr, k);
            end
        end
    end

    assign push     = out_valid && !bus.fifo_full;
    assign can_load = !out_valid || push;
    // nrst gates the accept so ARREADY stays low for the whole reset window.
    assign accept   = nrst && any_elig && can_load;
    assign ready    = accept ? (NUM_M'(1) << g) : '0;

    always_comb begin
        sel_id    = '0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (g == MIDX_W'(i)) begin
                sel_id    = bus.m_ARID[i*ID_WIDTH +: ID_WIDTH];
                sel_addr  = bus.m_ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len   = bus.m_ARLEN[i*LEN_WIDTH +: LEN_WIDTH];
                sel_size  = bus.m_ARSIZE[i*SIZE_WIDTH +: SIZE_WIDTH];
                sel_burst = bus.m_ARBURST[i*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_addr  <= '0;
            out_len   <= '0;
            out_size  <= '0;
            out_burst <= '0;
            for (int i = 0; i < NUM_M; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_id    <= {g, sel_id};
                out_addr  <= sel_addr;
                out_len   <= sel_len;
                out_size  <= sel_size;
                out_burst <= sel_burst;
                rr_ptr    <= (g == LAST_IDX) ? '0 : g + 1'b1;
            end else if (push) begin
                out_valid <= 1'b0;
            end
            // Accept and completion in the same cycle cancel; completions at zero are dropped.
            for (int i = 0; i < NUM_M; i++) begin
                if (ready[i] && !bus.r_done[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (bus.r_done[i] && !ready[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    assign bus.m_ARREADY  = ready;
    assign bus.push       = push;
    assign bus.out_ARID   = out_id;
    assign bus.out_ARADDR = out_addr;
    assign bus.out_ARLEN  = out_len;
    assign bus.out_ARSIZE = out_size;
    assign bus.out_ARBURST = out_burst;
endmodule
